// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver for the MM:SS BCD stopwatch count.
// Optional blink-on-stop is built when STOP_BLINK_EN is defined.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 8
) (
  input  logic        clk_in,
  input  logic        RESET,
  input  logic [15:0] bcd_in,
  input  logic        blank_lz,
  input  logic        colon_on,
  input  logic        running,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [PRE_W-1:0] pre_cnt;
  logic [1:0]       idx;
  logic [15:0]      snap;
  logic             first;
  logic             tick;
  logic [3:0]       nib;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign tick = (pre_cnt == PRE_W'(REFRESH_DIV - 1));
  assign nib  = snap[{idx, 2'b00} +: 4];

`ifdef STOP_BLINK_EN
  localparam int FR_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [FR_W-1:0] fr_cnt;
  logic            blink_ph;

  // Frame counter only advances while stopped, so running=1 always restarts the lit phase.
  always_ff @(posedge clk_in) begin
    if (RESET || running) begin
      fr_cnt   <= '0;
      blink_ph <= 1'b0;
    end else if (tick && idx == 2'd3) begin
      if (fr_cnt == FR_W'(BLINK_DIV - 1)) begin
        fr_cnt   <= '0;
        blink_ph <= ~blink_ph;
      end else begin
        fr_cnt <= fr_cnt + FR_W'(1);
      end
    end
  end
`else
  logic unused_running;
  assign unused_running = running ^ (BLINK_DIV == 0);
`endif

  always_ff @(posedge clk_in) begin
    if (RESET) begin
      pre_cnt <= '0;
      idx     <= 2'd0;
      snap    <= 16'h0000;
      first   <= 1'b1;
      an      <= 4'b1111;
      seg     <= 7'b1111111;
      dp      <= 1'b1;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      if (tick) idx <= idx + 2'd1;
      // Snapshot only at frame boundaries so a mid-scan count change cannot tear the display.
      if (first || (tick && idx == 2'd3)) snap <= bcd_in;
      first <= 1'b0;
      if (first) begin
        an  <= 4'b1111;
        seg <= 7'b1111111;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= (blank_lz && idx == 2'd3 && snap[15:12] == 4'd0) ? 7'b1111111
                                                               : seg_decode(nib);
        dp  <= ~(colon_on && idx == 2'd2);
`ifdef STOP_BLINK_EN
        if (!running && blink_ph) an <= 4'b1111;
`endif
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: per-edge expectations from an arithmetic model.
module tb_seg7_scan_driver;

  localparam int R  = 4;
  localparam int BD = 2;
  localparam int FRAME = 4 * R;

  logic        clk_in = 1'b0;
  logic        RESET;
  logic [15:0] bcd_in;
  logic        blank_lz;
  logic        colon_on;
  logic        running;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // Model state: edges since reset release, displayed snapshot, frames ended while stopped.
  int          k_m;
  logic [15:0] snap_m;
  int          fstop_m;

  logic [6:0] dec_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                               7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

  seg7_scan_driver #(.REFRESH_DIV(R), .BLINK_DIV(BD)) dut (
    .clk_in   (clk_in),
    .RESET    (RESET),
    .bcd_in   (bcd_in),
    .blank_lz (blank_lz),
    .colon_on (colon_on),
    .running  (running),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
        fails++;
        $display("FAIL scan @%0t: got an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                 $time, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  end

  task automatic step(input bit r);
    exp_t e;
    int   d;
    logic [3:0] n;
    RESET = r;
    e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1;
    if (r) begin
      k_m = 0; snap_m = 16'h0000; fstop_m = 0;
    end else begin
      k_m++;
      if (k_m > 1) begin
        d = ((k_m - 1) / R) % 4;
        n = 4'((snap_m >> (4 * d)) & 16'h000F);
        e.an  = ~(4'b0001 << d);
        e.seg = (blank_lz && d == 3 && n == 4'd0) ? 7'b1111111 : dec_tab[n];
        e.dp  = ~(colon_on && d == 2);
`ifdef STOP_BLINK_EN
        if (!running && ((fstop_m / BD) % 2 == 1)) e.an = 4'b1111;
`endif
      end
      if (k_m == 1 || (k_m % FRAME) == 0) snap_m = bcd_in;
      if (running) fstop_m = 0;
      else if ((k_m % FRAME) == 0) fstop_m++;
    end
    exp_q.push_back(e);
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_dark();
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
      fails++;
      $display("FAIL reset @%0t: got an=%b seg=%b dp=%b, required dark display",
               $time, an, seg, dp);
    end
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin
    int w;
    RESET = 1'b1; bcd_in = 16'h4930; blank_lz = 1'b0; colon_on = 1'b1; running = 1'b1;
    k_m = 0; snap_m = 16'h0000; fstop_m = 0;

    step(1'b1); step(1'b1);
    check_dark();
    run_n(2 * FRAME + 2);

    blank_lz = 1'b1; bcd_in = 16'h0125;
    run_n(2 * FRAME);

    // Mid-frame change while digit 1 is being scanned.
    blank_lz = 1'b0; bcd_in = 16'h1020;
    w = 0;
    while ((k_m % FRAME) != 0 && w <= FRAME) begin
      step(1'b0);
      w++;
    end
    checks++;
    if (w > FRAME) begin
      fails++;
      $display("FAIL wait @%0t: frame boundary not reached within %0d cycles", $time, FRAME);
    end
    run_n(R + 1);
    bcd_in = 16'h1021;
    run_n(2 * FRAME);

    bcd_in = 16'h0A00;
    run_n(2 * FRAME);

    // Reset while idx==2, then let the scan restart.
    step(1'b1);
    check_dark();
    run_n(2 * R + 1);
    step(1'b1);
    check_dark();
    run_n(FRAME + 3);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) bcd_in = 16'($urandom);
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 49) == 0) colon_on = ~colon_on;
      if ($urandom_range(0, 199) == 0) running = ~running;
      step($urandom_range(0, 299) == 0);
    end

    running = 1'b0; bcd_in = 16'h0815;
    run_n(10 * FRAME);
    running = 1'b1;
    run_n(FRAME);
    running = 1'b0;
    run_n(6 * FRAME);

    @(negedge clk_in);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
